imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV64I/RV32I datapath. It decodes every base-ISA immediate format (I, S, B, U, J) from a 32-bit instruction and sign-extends the result to XLEN. Operands move through a valid/ready handshake with a two-entry skid buffer, so the stage can sit between fetch/decode and execute without combinational ready paths.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept; depends only on internal state.
- instruction  in  32  raw instruction word.
- out_valid  out  1  decoded result available.
- out_ready  in  1  consumer accepts result.
- imm_data  out  XLEN  sign-extended immediate.
- imm_fmt  out  3  format code: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
- illegal  out  1  opcode not recognised (see Configuration).

## Operation
- Opcode is instruction[6:0]; decode is a full 7-bit match, not a bit test.
- I (LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111, SYSTEM 1110011): sext(inst[31:20]).
- S (STORE 0100011): sext({inst[31:25], inst[11:7]}).
- B (BRANCH 1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}). Bit 0 is always 0.
- U (LUI 0110111, AUIPC 0010111): sext({inst[31:12], 12'b0}). At XLEN=32 there is no extension.
- J (JAL 1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
- R (OP 0110011, OP-32 0111011): imm_data=0, imm_fmt=0.
- Any other opcode: imm_data=0, imm_fmt=0.
- Sign bit for all formats is inst[31], replicated to XLEN.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register full, skid empty, in_ready=1.
  - FULL: both full, in_ready=0.
- Transitions (acc = in_valid&in_ready, drn = out_valid&out_ready):
  - EMPTY: acc -> ONE.
  - ONE: acc&!drn -> FULL (new item goes to skid); !acc&drn -> EMPTY; acc&drn -> ONE (output register reloads from input).
  - FULL: drn -> ONE (skid moves to output register); otherwise hold.
- Ordering is strict FIFO; no item is dropped or duplicated.
- Output fields hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: 1 cycle. Accept at edge N gives out_valid at N+1, when starting from EMPTY.
- Throughput: 1 per cycle while out_ready=1.
- in_ready is registered (equal to !FULL). There is no combinational path from out_ready to in_ready.
- Reset (async assert, sync deassert handled upstream): state EMPTY, out_valid=0, in_ready=1, imm_data=0, imm_fmt=0, illegal=0. Skid contents are cleared.
- Reset mid-transfer discards both buffered items. The first post-reset accept behaves as from EMPTY.
- in_valid may drop without being accepted; the stage does not require it to be held.

## Configuration
- IMM_GEN_ILLEGAL_DET_EN defined:
  - illegal=1 alongside out_valid for any opcode outside the I/S/B/U/J/R lists, including custom-0 0001011.
  - illegal is also set when inst[1:0] != 2'b11.
  - illegal is carried through the skid buffer with its item.
- Undefined: illegal is tied to 0. The unrecognised-opcode datapath behaviour (imm=0, fmt=0) is unchanged.

## Test plan
- XLEN=64, out_ready=1. Inputs: 0xFF813083 (ld x1,-8(x2)), 0xFE113823 (sd x1,-16(x2)), 0xFE000EE3 (beq -4) on consecutive cycles -> one cycle later, three consecutive results: 0xFFFFFFFFFFFFFFF8/fmt1, 0xFFFFFFFFFFFFFFF0/fmt2, 0xFFFFFFFFFFFFFFFC/fmt3.
- U and J formats:
  - 0x123452B7 -> 0x0000000012345000, fmt4.
  - 0x800002B7 -> 0xFFFFFFFF80000000.
  - 0x001000EF (jal +2048) -> 0x800, fmt5.
  - Repeat at XLEN=32: 0x80000000 for 0x800002B7.
- Backpressure: out_ready=0, in_valid=1 with 4 distinct items -> first two accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> items emerge in order, 1 per cycle, none lost.
- Simultaneous events: in ONE state, assert acc and drn in the same cycle -> state stays ONE and the output updates to the new item next cycle. In FULL, drn alone -> in_ready=1 next cycle.
- Reset: pull rst_n low while FULL -> out_valid=0, in_ready=1, imm_data=0 immediately, without waiting for a clock edge. After release, the first item appears 1 cycle after accept.
- Illegal opcode: 0x0000000B and 0x00000013 with a forced inst[1:0]=00 -> with IMM_GEN_ILLEGAL_DET_EN, illegal=1, imm=0, fmt=0. Without it, illegal=0 and imm=0, fmt=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder behind a two-entry skid buffer.
// Define IMM_GEN_ILLEGAL_DET_EN to flag unrecognised opcodes on the illegal output.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_data,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpOp32    = 7'b0111011;

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      state_q, state_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  entry_t      dec;
  logic [31:0] imm32;
  logic        acc, drn;

  // Every format's immediate fits in 32 bits with inst[31] as its sign bit,
  // so decode at 32 bits and sign-extend once to XLEN.
  always_comb begin
    imm32   = '0;
    dec.fmt = FmtNone;
`ifdef IMM_GEN_ILLEGAL_DET_EN
    dec.ill = (instruction[1:0] != 2'b11);
`else
    dec.ill = 1'b0;
`endif
    case (instruction[6:0])
      OpLoad, OpOpImm, OpOpImm32, OpJalr, OpSystem: begin
        imm32   = {{20{instruction[31]}}, instruction[31:20]};
        dec.fmt = FmtI;
      end
      OpStore: begin
        imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        dec.fmt = FmtS;
      end
      OpBranch: begin
        imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
        dec.fmt = FmtB;
      end
      OpLui, OpAuipc: begin
        imm32   = {instruction[31:12], 12'b0};
        dec.fmt = FmtU;
      end
      OpJal: begin
        imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
        dec.fmt = FmtJ;
      end
      OpOp, OpOp32: begin
        dec.fmt = FmtNone;
      end
      default: begin
`ifdef IMM_GEN_ILLEGAL_DET_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // Handshake flags come only from the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (acc) begin
          out_d   = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (acc && !drn) begin
          skid_d  = dec;
          state_d = StFull;
        end else if (acc && drn) begin
          out_d = dec;
        end else if (drn) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drn) begin
          out_d   = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign imm_data = out_q.imm;
  assign imm_fmt  = out_q.fmt;
  assign illegal  = out_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus randomized traffic
// checked against an arithmetic decode model and a queue model of the buffer.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ILLEGAL_DET_EN
  localparam bit IllegalEn = 1'b1;
`else
  localparam bit IllegalEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic        in_ready, out_valid, illegal;
  logic [63:0] imm_data;
  logic [2:0]  imm_fmt;
  logic        in_ready32, out_valid32, illegal32;
  logic [31:0] imm_data32;
  logic [2:0]  imm_fmt32;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t mq[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .imm_data(imm_data), .imm_fmt(imm_fmt), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_data(imm_data32), .imm_fmt(imm_fmt32), .illegal(illegal32)
  );

  // Immediates rebuilt with signed shifts and masks on the sign-extended word.
  function automatic exp_t ref_decode(input logic [31:0] inst);
    exp_t   e;
    longint s;
    s     = longint'(signed'(inst));
    e.imm = '0;
    e.fmt = 3'd0;
    e.ill = IllegalEn && (inst[1:0] != 2'b11);
    case (inst[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
        e.imm = s >>> 20;
        e.fmt = 3'd1;
      end
      7'h23: begin
        e.imm = ((s >>> 25) << 5) | ((s >> 7) & 31);
        e.fmt = 3'd2;
      end
      7'h63: begin
        e.imm = ((s >>> 31) << 12) | (((s >> 7) & 1) << 11) | (((s >> 25) & 63) << 5)
              | (((s >> 8) & 15) << 1);
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin
        e.imm = s & -4096;
        e.fmt = 3'd4;
      end
      7'h6F: begin
        e.imm = ((s >>> 31) << 20) | (((s >> 12) & 255) << 12) | (((s >> 20) & 1) << 11)
              | (((s >> 21) & 1023) << 1);
        e.fmt = 3'd5;
      end
      7'h33, 7'h3B: ;
      default: e.ill = IllegalEn;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [16] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                              7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0B, 7'h10, 7'h7F, 7'h00};
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 15)]};
  endfunction

  // Advance one clock and update the occupancy model from the driven inputs.
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (drn) void'(mq.pop_front());
    if (acc) mq.push_back(ref_decode(instruction));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (imm_data !== 64'd0) $display("FAIL reset_imm got %h want 0", imm_data); else n_pass++;
    n_checks++; if (imm_fmt !== 3'd0) $display("FAIL reset_fmt got %0d want 0", imm_fmt); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", illegal); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_formats();
    logic [31:0] insts [6] = '{32'hFF813083, 32'hFE113823, 32'hFE000EE3,
                               32'h123452B7, 32'h800002B7, 32'h001000EF};
    logic [63:0] imms [6] = '{64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF0, 64'hFFFFFFFFFFFFFFFC,
                              64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h0000000000000800};
    logic [31:0] imms32 [6] = '{32'hFFFFFFF8, 32'hFFFFFFF0, 32'hFFFFFFFC,
                                32'h12345000, 32'h80000000, 32'h00000800};
    logic [2:0]  fmts [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      instruction = insts[i];
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL fmt%0d_valid got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (imm_data !== imms[i]) $display("FAIL fmt%0d_imm got %h want %h", i, imm_data, imms[i]); else n_pass++;
      n_checks++; if (imm_fmt !== fmts[i]) $display("FAIL fmt%0d_code got %0d want %0d", i, imm_fmt, fmts[i]); else n_pass++;
      n_checks++; if (imm_data32 !== imms32[i]) $display("FAIL fmt%0d_imm32 got %h want %h", i, imm_data32, imms32[i]); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fmt_drain_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] insts [2] = '{32'h0000000B, 32'h00000010};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid    = 1'b1;
      instruction = insts[i];
      tick();
      n_checks++; if (illegal !== IllegalEn) $display("FAIL ill%0d_flag got %b want %b", i, illegal, IllegalEn); else n_pass++;
      n_checks++; if (illegal32 !== IllegalEn) $display("FAIL ill%0d_flag32 got %b want %b", i, illegal32, IllegalEn); else n_pass++;
      n_checks++; if (imm_data !== 64'd0) $display("FAIL ill%0d_imm got %h want 0", i, imm_data); else n_pass++;
      n_checks++; if (imm_fmt !== 3'd0) $display("FAIL ill%0d_fmt got %0d want 0", i, imm_fmt); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h00500093;
    tick();
    out_ready   = 1'b1;
    instruction = 32'h00700093;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL sim_one_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (imm_data !== 64'd7) $display("FAIL sim_one_imm got %h want 7", imm_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL sim_one_ready got %b want 1", in_ready); else n_pass++;
    out_ready   = 1'b0;
    instruction = 32'h00900093;
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL sim_full_ready got %b want 0", in_ready); else n_pass++;
    n_checks++; if (imm_data !== 64'd7) $display("FAIL sim_full_hold got %h want 7", imm_data); else n_pass++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL sim_drain_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (imm_data !== 64'd9) $display("FAIL sim_drain_imm got %h want 9", imm_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL sim_empty_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] items [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'hFFF00093};
    logic [63:0] exps [4] = '{64'd1, 64'd2, 64'd3, 64'hFFFFFFFFFFFFFFFF};
    int idx = 0;
    bit room;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid    = 1'b1;
      instruction = items[idx];
      room        = (mq.size() < 2);
      tick();
      if (room) idx++;
      n_checks++; if (in_ready !== (c == 0)) $display("FAIL bp_ready_c%0d got %b want %b", c, in_ready, c == 0); else n_pass++;
      n_checks++; if (imm_data !== exps[0]) $display("FAIL bp_hold_c%0d got %h want %h", c, imm_data, exps[0]); else n_pass++;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out%0d_valid got %b want 1", c, out_valid); else n_pass++;
      n_checks++; if (imm_data !== exps[c]) $display("FAIL bp_out%0d_imm got %h want %h", c, imm_data, exps[c]); else n_pass++;
      in_valid = (idx < 4);
      if (idx < 4) instruction = items[idx];
      room = (mq.size() < 2);
      tick();
      if (room && idx < 4) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_end_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'hFE113823;
    tick();
    instruction = 32'h001000EF;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL ar_full_ready got %b want 0", in_ready); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (imm_data !== 64'd0) $display("FAIL ar_imm got %h want 0", imm_data); else n_pass++;
    n_checks++; if (imm_fmt !== 3'd0) $display("FAIL ar_fmt got %0d want 0", imm_fmt); else n_pass++;
    mq.delete();
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    instruction = 32'h12345037;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_pre_valid got %b want 0", out_valid); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ar_first_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (imm_data !== 64'h12345000) $display("FAIL ar_first_imm got %h want 12345000", imm_data); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t h;
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      instruction = rand_inst();
      tick();
      n_checks++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd%0d_valid got %b want %b", c, out_valid, mq.size() > 0); else n_pass++;
      n_checks++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd%0d_ready got %b want %b", c, in_ready, mq.size() < 2); else n_pass++;
      if (mq.size() > 0) begin
        h = mq[0];
        n_checks++; if (imm_data !== h.imm) $display("FAIL rnd%0d_imm got %h want %h", c, imm_data, h.imm); else n_pass++;
        n_checks++; if (imm_fmt !== h.fmt) $display("FAIL rnd%0d_fmt got %0d want %0d", c, imm_fmt, h.fmt); else n_pass++;
        n_checks++; if (illegal !== h.ill) $display("FAIL rnd%0d_ill got %b want %b", c, illegal, h.ill); else n_pass++;
        n_checks++; if (imm_data32 !== h.imm[31:0]) $display("FAIL rnd%0d_imm32 got %h want %h", c, imm_data32, h.imm[31:0]); else n_pass++;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_illegal();
    test_simultaneous();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
